// File: rtl/mem_lane_arbiter.sv
// Memory-stage lane arbiter: takes one batch of up to NUM_LANES load/store ops
// from the EX/Mem register and serialises them, lowest lane first, onto a
// single-port Dcache request/grant/response interface. The pipeline is stalled
// until the batch retires. Load results are returned per lane, and misaligned
// accesses are flagged and never issued.
module mem_lane_arbiter #(
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_LANES-1:0]             ex_valid,
    input  logic [NUM_LANES-1:0]             ex_ld,
    input  logic [NUM_LANES-1:0]             ex_st,
    input  logic [2*NUM_LANES-1:0]           ex_width,
    input  logic [NUM_LANES-1:0]             ex_sign,
    input  logic [ADDR_WIDTH*NUM_LANES-1:0]  ex_addr,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]  ex_wdata,
    input  logic                             flush,
    output logic                             dc_req,
    output logic                             dc_we,
    output logic [1:0]                       dc_width,
    output logic                             dc_sign,
    output logic [ADDR_WIDTH-1:0]            dc_addr,
    output logic [DATA_WIDTH-1:0]            dc_wdata,
    input  logic                             dc_gnt,
    input  logic                             dc_rvalid,
    input  logic [DATA_WIDTH-1:0]            dc_rdata,
    output logic                             mem_stall,
    output logic                             mem_done,
    output logic [DATA_WIDTH*NUM_LANES-1:0]  mem_rdata,
    output logic [NUM_LANES-1:0]             mem_misalign
);

    localparam int unsigned IdxW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

    state_e                          state_q;
    logic [NUM_LANES-1:0]            pending_q;
    logic                            cancel_q;
    logic [DATA_WIDTH*NUM_LANES-1:0] rdata_q;

    logic [NUM_LANES-1:0]            eligible;
    logic [NUM_LANES-1:0]            sel_oh;
    logic [NUM_LANES-1:0]            pending_next;
    logic [IdxW-1:0]                 sel_idx;

    logic [1:0]                      lane_width [NUM_LANES];
    logic [ADDR_WIDTH-1:0]           lane_addr  [NUM_LANES];
    logic [DATA_WIDTH-1:0]           lane_wdata [NUM_LANES];

    // Per-lane field unpacking plus alignment decode.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic mem_op;
        logic bad_align;

        assign lane_width[g] = ex_width[2*g +: 2];
        assign lane_addr[g]  = ex_addr[ADDR_WIDTH*g +: ADDR_WIDTH];
        assign lane_wdata[g] = ex_wdata[DATA_WIDTH*g +: DATA_WIDTH];

        assign mem_op    = ex_valid[g] & (ex_ld[g] | ex_st[g]);
        assign bad_align = ((lane_width[g] == 2'b01) & lane_addr[g][0])
                         | ((lane_width[g] == 2'b10) & (lane_addr[g][1:0] != 2'b00))
                         |  (lane_width[g] == 2'b11);

        assign mem_misalign[g] = mem_op & bad_align;
        assign eligible[g]     = mem_op & ~bad_align;
    end

    // Lowest pending lane wins; pending only changes on grant/response, so the
    // selection (and therefore the request fields) is stable while waiting.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = IdxW'(i);
            end
        end
    end

    assign sel_oh       = pending_q & (~pending_q + NUM_LANES'(1));
    assign pending_next = pending_q & ~sel_oh;

    // Dcache request fields and pipeline stall, decoded from the current state.
    always_comb begin
        dc_req    = 1'b0;
        dc_we     = 1'b0;
        dc_width  = 2'b00;
        dc_sign   = 1'b0;
        dc_addr   = '0;
        dc_wdata  = '0;
        mem_stall = 1'b0;
        unique case (state_q)
            StIdle: begin
                mem_stall = (|eligible) & ~flush;
            end
            StReq: begin
                // Flush gates the request in the same cycle so a grant cannot land.
                dc_req    = ~flush;
                dc_we     = ex_st[sel_idx];
                dc_width  = lane_width[sel_idx];
                dc_sign   = ex_sign[sel_idx];
                dc_addr   = lane_addr[sel_idx];
                dc_wdata  = lane_wdata[sel_idx];
                mem_stall = 1'b1;
            end
            StWait: begin
                mem_stall = 1'b1;
            end
            StDone: begin
                mem_stall = 1'b0;
            end
        endcase
    end

    assign mem_done  = (state_q == StDone);
    assign mem_rdata = rdata_q;

    // Batch sequencing: capture, issue, collect responses, retire or cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            cancel_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if ((|eligible) && !flush) begin
                        pending_q <= eligible;
                        rdata_q   <= '0;
                        cancel_q  <= 1'b0;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (flush) begin
                        pending_q <= '0;
                        state_q   <= StIdle;
                    end else if (dc_gnt) begin
                        if (ex_ld[sel_idx]) begin
                            state_q <= StWait;
                        end else begin
                            pending_q <= pending_next;
                            state_q   <= (pending_next == '0) ? StDone : StReq;
                        end
                    end
                end
                StWait: begin
                    if (dc_rvalid) begin
                        if (cancel_q || flush) begin
                            // Response consumed but discarded; batch is abandoned.
                            pending_q <= '0;
                            cancel_q  <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            for (int i = 0; i < NUM_LANES; i++) begin
                                if (sel_oh[i]) begin
                                    rdata_q[DATA_WIDTH*i +: DATA_WIDTH] <= dc_rdata;
                                end
                            end
                            pending_q <= pending_next;
                            state_q   <= (pending_next == '0) ? StDone : StReq;
                        end
                    end else if (flush) begin
                        cancel_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // A lane must never be both a load and a store.
    a_ld_st_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(|(ex_valid & ex_ld & ex_st)));

endmodule
